tetris_game_ctrl: RTL and testbench
===================================

TETRIS_GAME_CTRL -- requirements
Module: tetris_game_ctrl

Interface
REQ-001 The block SHALL have parameter ROWS, default 11, meaning number of board rows (row 0 = bottom).
REQ-002 The block SHALL have parameter DROP_PERIOD, default 8, meaning clka cycles per gravity step in MOVE (legal range >= 2).
REQ-003 The block SHALL have parameter SCORE_W, default 16, meaning width of the lines-cleared counter.
REQ-004 The block SHALL derive local ROW_W = $clog2(ROWS) and DROP_W = $clog2(DROP_PERIOD).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clka  input  1  sole clock, all state on rising edge.
REQ-006 restart  input  1  synchronous active-high reset.
REQ-007 start  input  1  begin game; honoured only in NEWBOARD or GAMEOVER.
REQ-008 touched  input  1  falling piece has landed; sampled in MOVE.
REQ-009 full_rows  input  ROWS  bitmask of complete rows; sampled in LAND only.
REQ-010 spawn_blocked  input  1  generated piece overlaps stack; sampled with dp_ack in GEN.
REQ-011 dp_ack  input  1  datapath completed the currently requested operation.
REQ-012 gen_req  output  1  request new piece; held high in GEN until dp_ack.
REQ-013 clr_req  output  1  request row clear; held high in CLEAR until dp_ack.
REQ-014 clr_row  output  ROW_W  row index to clear; valid while clr_req is high.
REQ-015 drop_tick  output  1  one-cycle gravity pulse.
REQ-016 state  output  3  current state encoding.
REQ-017 game_over  output  1  high while in GAMEOVER.

Function
REQ-018 The state encoding SHALL be: NEWBOARD=0, GEN=1, MOVE=2, LAND=3, CLEAR=4, GAMEOVER=5; codes 6-7 SHALL transition to NEWBOARD on the next cycle.
REQ-019 NEWBOARD: start=1 -> GEN; else stay.
REQ-020 GEN: gen_req=1; dp_ack=1 with spawn_blocked=1 -> GAMEOVER; dp_ack=1 with spawn_blocked=0 -> MOVE; else stay.
REQ-021 MOVE: drop counter SHALL count 0..DROP_PERIOD-1 and wrap; drop_tick=1 in the cycle the counter equals DROP_PERIOD-1; counter SHALL be cleared on MOVE entry.
REQ-022 MOVE: touched=1 -> LAND; touched SHALL take priority over drop_tick in the same cycle (drop_tick forced 0).
REQ-023 LAND: one cycle; full_rows SHALL be latched into a pending mask; mask==0 -> GEN, else CLEAR.
REQ-024 CLEAR: clr_row SHALL be the highest set index of the pending mask (top row first, so lower indices stay valid after rows shift down).
REQ-025 CLEAR: on dp_ack the pending bit for clr_row SHALL clear; if the mask becomes zero -> GEN, else stay, with clr_req remaining high and clr_row updating the next cycle.
REQ-026 GAMEOVER: game_over=1; start=1 -> NEWBOARD.
REQ-027 dp_ack SHALL be ignored in states other than GEN and CLEAR.
REQ-028 gen_req, clr_req, drop_tick and game_over SHALL be registered outputs, decoded from the registered state and counter.

Reset
REQ-029 restart=1 SHALL override all inputs and, on the next edge, set state=NEWBOARD, pending mask=0, drop counter=0, all request/pulse outputs=0, clr_row=0, and lines_cleared=0.
REQ-030 restart asserted mid-CLEAR or mid-GEN SHALL abandon the request without waiting for dp_ack.

Configuration
REQ-031 With macro TETRIS_SCORE_EN defined, the block SHALL add output lines_cleared (SCORE_W) that increments by 1 per accepted CLEAR dp_ack, saturating at all-ones, and clears on restart or on NEWBOARD->GEN.
REQ-032 Without TETRIS_SCORE_EN, the lines_cleared port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 Package tetris_pkg SHALL hold the state typedef/encoding and default ROWS.
REQ-034 Highest-set-bit selection SHALL be a sub-module tetris_row_prienc (parameter ROWS, outputs index plus any-set flag).

Verification
REQ-035 restart, start, GEN with dp_ack and spawn_blocked=0 -> MOVE; drop_tick every 8 cycles with DROP_PERIOD=8.
REQ-036 In MOVE, touched and counter=7 in the same cycle -> drop_tick=0, next state LAND.
REQ-037 LAND with full_rows=11'b000_0010_0101 -> clr_row 5, 2, 0 on successive acks, then GEN; lines_cleared=3 with TETRIS_SCORE_EN.
REQ-038 LAND with full_rows=0 -> GEN after exactly one cycle, clr_req never asserted.
REQ-039 GEN with dp_ack and spawn_blocked=1 -> GAMEOVER, game_over=1; start -> NEWBOARD.
REQ-040 restart during CLEAR with pending mask nonzero -> NEWBOARD next cycle, clr_req=0, and a late dp_ack has no effect.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris game controller.
//   - DEFAULT_ROWS: default board height (row 0 = bottom)
//   - state_t / S_*: controller state encoding
package tetris_pkg;

    localparam int unsigned DEFAULT_ROWS = 11;
    localparam int unsigned STATE_W      = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] S_NEWBOARD = 3'd0;
    localparam logic [2:0] S_GEN      = 3'd1;
    localparam logic [2:0] S_MOVE     = 3'd2;
    localparam logic [2:0] S_LAND     = 3'd3;
    localparam logic [2:0] S_CLEAR    = 3'd4;
    localparam logic [2:0] S_GAMEOVER = 3'd5;

endpackage

// File: rtl/tetris_game_ctrl_if.sv
// Request/acknowledge handshake between the game controller and the board datapath.
//   gen_req       : controller -> datapath, generate a new piece
//   clr_req       : controller -> datapath, clear row clr_row
//   clr_row       : controller -> datapath, row index to clear
//   dp_ack        : datapath -> controller, current request completed
//   spawn_blocked : datapath -> controller, new piece overlaps the stack (valid with dp_ack)
interface tetris_game_ctrl_if
    import tetris_pkg::*;
#(
    parameter int unsigned ROWS = DEFAULT_ROWS
);
    localparam int unsigned ROW_W = $clog2(ROWS);

    logic             gen_req;
    logic             clr_req;
    logic [ROW_W-1:0] clr_row;
    logic             dp_ack;
    logic             spawn_blocked;

    modport master (
        output gen_req,
        output clr_req,
        output clr_row,
        input  dp_ack,
        input  spawn_blocked
    );

    modport slave (
        input  gen_req,
        input  clr_req,
        input  clr_row,
        output dp_ack,
        output spawn_blocked
    );

endinterface

// File: rtl/tetris_row_prienc.sv
// Highest-set-bit encoder over a row mask.
//   mask    : input  ROWS   rows to search
//   idx     : output ROW_W  index of the highest set bit (0 when mask is empty)
//   any_set : output 1      mask has at least one bit set
module tetris_row_prienc
    import tetris_pkg::*;
#(
    parameter int unsigned ROWS = DEFAULT_ROWS
) (
    input  logic [ROWS-1:0]          mask,
    output logic [$clog2(ROWS)-1:0]  idx,
    output logic                     any_set
);

    localparam int unsigned ROW_W = $clog2(ROWS);

    // Ascending scan; the last hit is the highest set row.
    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            if (mask[i]) begin
                idx     = ROW_W'(i);
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tetris_game_ctrl.sv
// Tetris game sequencing controller: piece generation, gravity ticks, landing and
// top-down row clearing, with a game-over state.
//   clka          : input  1      sole clock
//   restart       : input  1      synchronous active-high reset
//   start         : input  1      begin game (NEWBOARD / GAMEOVER only)
//   touched       : input  1      falling piece landed (MOVE)
//   full_rows     : input  ROWS   complete-row mask (LAND)
//   drop_tick     : output 1      gravity pulse
//   state         : output 3      current state
//   game_over     : output 1      high in GAMEOVER
//   lines_cleared : output SCORE_W  cleared-line count (only with TETRIS_SCORE_EN)
//   dp            : tetris_game_ctrl_if.master datapath handshake
// Optional feature macro: TETRIS_SCORE_EN.
module tetris_game_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned ROWS        = DEFAULT_ROWS,
    parameter int unsigned DROP_PERIOD = 8,
    parameter int unsigned SCORE_W     = 16
) (
    input  logic                clka,
    input  logic                restart,
    input  logic                start,
    input  logic                touched,
    input  logic [ROWS-1:0]     full_rows,
    output logic                drop_tick,
    output logic [2:0]          state,
    output logic                game_over,
    tetris_game_ctrl_if.master  dp
`ifdef TETRIS_SCORE_EN
    ,
    output logic [SCORE_W-1:0]  lines_cleared
`endif
);

    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned DROP_W = $clog2(DROP_PERIOD);
    localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(DROP_PERIOD - 1);

    if (DROP_PERIOD < 2 || SCORE_W < 1) begin : g_cfg_check
        $error("tetris_game_ctrl: DROP_PERIOD must be >= 2 and SCORE_W >= 1");
    end

    logic [2:0]        state_nxt;
    logic [DROP_W-1:0] cnt;
    logic [DROP_W-1:0] cnt_nxt;
    logic [ROWS-1:0]   pending;
    logic [ROWS-1:0]   pending_nxt;
    logic              tick_nxt;
    logic [ROW_W-1:0]  hi_idx;
    logic              hi_any;

    // Next row to clear is picked from the post-update mask so clr_row is ready
    // in the same cycle the controller (re)enters CLEAR.
    tetris_row_prienc #(
        .ROWS (ROWS)
    ) u_prienc (
        .mask    (pending_nxt),
        .idx     (hi_idx),
        .any_set (hi_any)
    );

    // Next-state, drop counter and pending-mask update.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        pending_nxt = pending;
        tick_nxt    = 1'b0;
        case (state)
            S_NEWBOARD: begin
                if (start) state_nxt = S_GEN;
            end
            S_GEN: begin
                if (dp.dp_ack) state_nxt = dp.spawn_blocked ? S_GAMEOVER : S_MOVE;
            end
            S_MOVE: begin
                // A landing suppresses the gravity step decided in the same cycle.
                if (touched) begin
                    state_nxt = S_LAND;
                end else begin
                    tick_nxt = (cnt == DROP_LAST);
                    cnt_nxt  = (cnt == DROP_LAST) ? '0 : cnt + DROP_W'(1);
                end
            end
            S_LAND: begin
                pending_nxt = full_rows;
                state_nxt   = (full_rows == '0) ? S_GEN : S_CLEAR;
            end
            S_CLEAR: begin
                if (dp.dp_ack) begin
                    pending_nxt = pending & ~(ROWS'(1) << dp.clr_row);
                    if (pending_nxt == '0) state_nxt = S_GEN;
                end
            end
            S_GAMEOVER: begin
                if (start) state_nxt = S_NEWBOARD;
            end
            default: begin
                state_nxt = S_NEWBOARD;
            end
        endcase
    end

    // State, counter and registered outputs; outputs track the state being entered.
    always_ff @(posedge clka) begin
        if (restart) begin
            state      <= S_NEWBOARD;
            cnt        <= '0;
            pending    <= '0;
            drop_tick  <= 1'b0;
            game_over  <= 1'b0;
            dp.gen_req <= 1'b0;
            dp.clr_req <= 1'b0;
            dp.clr_row <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pending    <= pending_nxt;
            drop_tick  <= tick_nxt;
            game_over  <= (state_nxt == S_GAMEOVER);
            dp.gen_req <= (state_nxt == S_GEN);
            dp.clr_req <= (state_nxt == S_CLEAR) && hi_any;
            dp.clr_row <= hi_idx;
        end
    end

`ifdef TETRIS_SCORE_EN
    // Saturating count of acknowledged row clears; reset at the start of each game.
    always_ff @(posedge clka) begin
        if (restart) begin
            lines_cleared <= '0;
        end else if (state == S_NEWBOARD && start) begin
            lines_cleared <= '0;
        end else if (state == S_CLEAR && dp.dp_ack && lines_cleared != '1) begin
            lines_cleared <= lines_cleared + SCORE_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Self-checking bench for tetris_game_ctrl: directed vector table, a drop-period
// sequence, then randomized stimulus against a queue-based behavioural model.
module tb_tetris_game_ctrl;

    localparam int unsigned ROWS        = 11;
    localparam int unsigned DROP_PERIOD = 8;
    localparam int unsigned SCORE_W     = 16;
    localparam int          SCORE_MAX   = (1 << SCORE_W) - 1;

    logic            clka = 1'b0;
    logic            restart;
    logic            start;
    logic            touched;
    logic [ROWS-1:0] full_rows;
    logic            drop_tick;
    logic [2:0]      state;
    logic            game_over;
`ifdef TETRIS_SCORE_EN
    logic [SCORE_W-1:0] lines_cleared;
`endif

    tetris_game_ctrl_if #(.ROWS(ROWS)) dpif ();

    tetris_game_ctrl #(
        .ROWS        (ROWS),
        .DROP_PERIOD (DROP_PERIOD),
        .SCORE_W     (SCORE_W)
    ) dut (
        .clka          (clka),
        .restart       (restart),
        .start         (start),
        .touched       (touched),
        .full_rows     (full_rows),
        .drop_tick     (drop_tick),
        .state         (state),
        .game_over     (game_over),
        .dp            (dpif)
`ifdef TETRIS_SCORE_EN
        ,
        .lines_cleared (lines_cleared)
`endif
    );

    always #5 clka = ~clka;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    // Phases: 0 newboard, 1 gen, 2 move, 3 land, 4 clear, 5 gameover.
    int m_state = 0;
    int m_age   = 0;      // cycles spent in MOVE since entry
    int m_pend[$];        // rows left to clear, top row first
    bit m_tick  = 0;
    int m_score = 0;

    task automatic model_edge();
        m_tick = 0;
        if (restart) begin
            m_state = 0; m_age = 0; m_pend.delete(); m_score = 0;
        end else begin
            case (m_state)
                0: if (start) begin m_state = 1; m_score = 0; end
                1: if (dpif.dp_ack) begin
                       m_state = dpif.spawn_blocked ? 5 : 2;
                       m_age = 0;
                   end
                2: if (touched) m_state = 3;
                   else begin
                       m_tick = ((m_age % DROP_PERIOD) == DROP_PERIOD - 1);
                       m_age++;
                   end
                3: begin
                       m_pend.delete();
                       for (int i = ROWS - 1; i >= 0; i--)
                           if (full_rows[i]) m_pend.push_back(i);
                       m_state = (m_pend.size() == 0) ? 1 : 4;
                   end
                4: if (dpif.dp_ack) begin
                       void'(m_pend.pop_front());
                       if (m_score < SCORE_MAX) m_score++;
                       if (m_pend.size() == 0) m_state = 1;
                   end
                5: if (start) m_state = 0;
                default: m_state = 0;
            endcase
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_in(input bit r, input bit s, input bit t, input bit a,
                          input bit sb, input logic [ROWS-1:0] f);
        restart = r; start = s; touched = t;
        dpif.dp_ack = a; dpif.spawn_blocked = sb; full_rows = f;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clka);
        #1;
    endtask

    task automatic check_score();
`ifdef TETRIS_SCORE_EN
        check("lines_cleared", 32'(lines_cleared), 32'(m_score));
`endif
    endtask

    task automatic check_model();
        int exp_row;
        exp_row = (m_state == 4 && m_pend.size() > 0) ? m_pend[0] : 0;
        check("state",     32'(state),        32'(m_state));
        check("gen_req",   32'(dpif.gen_req), 32'(m_state == 1));
        check("clr_req",   32'(dpif.clr_req), 32'(m_state == 4));
        check("clr_row",   32'(dpif.clr_row), 32'(exp_row));
        check("drop_tick", 32'(drop_tick),    32'(m_tick));
        check("game_over", 32'(game_over),    32'(m_state == 5));
        check_score();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit              rst, st, tch, ack, sb;
        logic [ROWS-1:0] full;
        logic [2:0]      e_state;
        bit              e_gen, e_clr;
        logic [3:0]      e_row;
        bit              e_tick, e_go;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, bit s, bit t, bit a, bit sb, logic [ROWS-1:0] f,
                                int es, bit eg, bit ec, int er, bit et, bit eo);
        vec_t v;
        v.rst = r; v.st = s; v.tch = t; v.ack = a; v.sb = sb; v.full = f;
        v.e_state = 3'(es); v.e_gen = eg; v.e_clr = ec; v.e_row = 4'(er);
        v.e_tick = et; v.e_go = eo;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int first_tick;
        int second_tick;
        set_in(1, 0, 0, 0, 0, '0);

        //   rst st tch ack sb full           st gen clr row tick go
        add(1, 0, 0, 0, 0, 11'h000,          0, 0, 0, 0, 0, 0);  // reset
        add(0, 1, 0, 0, 0, 11'h000,          1, 1, 0, 0, 0, 0);  // start -> GEN
        add(0, 0, 0, 0, 0, 11'h000,          1, 1, 0, 0, 0, 0);  // gen_req held
        add(0, 0, 0, 1, 0, 11'h000,          2, 0, 0, 0, 0, 0);  // ack -> MOVE
        for (int i = 0; i < 7; i++)
            add(0, 0, 0, 0, 0, 11'h000,      2, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 11'h000,          2, 0, 0, 0, 1, 0);  // counter at 7 -> tick
        for (int i = 0; i < 7; i++)
            add(0, 0, 0, 0, 0, 11'h000,      2, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 11'h000,          3, 0, 0, 0, 0, 0);  // touched beats tick
        add(0, 0, 0, 0, 0, 11'h025,          4, 0, 1, 5, 0, 0);  // LAND -> CLEAR row 5
        add(0, 0, 0, 0, 0, 11'h000,          4, 0, 1, 5, 0, 0);  // waits for ack
        add(0, 0, 0, 1, 0, 11'h000,          4, 0, 1, 2, 0, 0);
        add(0, 0, 0, 1, 0, 11'h000,          4, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 11'h000,          1, 1, 0, 0, 0, 0);  // mask empty -> GEN
        add(0, 0, 0, 1, 0, 11'h000,          2, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 11'h000,          3, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 11'h000,          1, 1, 0, 0, 0, 0);  // empty LAND -> GEN
        add(0, 0, 0, 1, 1, 11'h000,          5, 0, 0, 0, 0, 1);  // blocked -> GAMEOVER
        add(0, 0, 0, 1, 0, 11'h000,          5, 0, 0, 0, 0, 1);  // ack ignored
        add(0, 1, 0, 0, 0, 11'h000,          0, 0, 0, 0, 0, 0);  // start -> NEWBOARD
        add(0, 0, 0, 1, 0, 11'h000,          0, 0, 0, 0, 0, 0);  // ack ignored
        add(0, 1, 0, 0, 0, 11'h000,          1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 11'h000,          2, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 11'h000,          3, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 11'h401,          4, 0, 1, 10, 0, 0);
        add(1, 1, 0, 1, 0, 11'h7FF,          0, 0, 0, 0, 0, 0);  // restart mid-CLEAR
        add(0, 0, 0, 1, 0, 11'h000,          0, 0, 0, 0, 0, 0);  // late ack: no effect
        add(0, 1, 0, 0, 0, 11'h000,          1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 11'h000,          0, 0, 0, 0, 0, 0);  // restart mid-GEN

        foreach (tbl[k]) begin
            set_in(tbl[k].rst, tbl[k].st, tbl[k].tch, tbl[k].ack, tbl[k].sb, tbl[k].full);
            cycle();
            check("t_state",     32'(state),        32'(tbl[k].e_state));
            check("t_gen_req",   32'(dpif.gen_req), 32'(tbl[k].e_gen));
            check("t_clr_req",   32'(dpif.clr_req), 32'(tbl[k].e_clr));
            check("t_clr_row",   32'(dpif.clr_row), 32'(tbl[k].e_row));
            check("t_drop_tick", 32'(drop_tick),    32'(tbl[k].e_tick));
            check("t_game_over", 32'(game_over),    32'(tbl[k].e_go));
            check_score();
        end

        // Gravity period: first tick DROP_PERIOD cycles after MOVE entry, then every DROP_PERIOD.
        set_in(1, 0, 0, 0, 0, '0); cycle(); check_model();
        set_in(0, 1, 0, 0, 0, '0); cycle(); check_model();
        set_in(0, 0, 0, 1, 0, '0); cycle(); check_model();
        set_in(0, 0, 0, 0, 0, '0);
        first_tick = -1;
        second_tick = -1;
        for (int c = 1; c <= 40 && second_tick < 0; c++) begin
            cycle();
            check_model();
            if (drop_tick === 1'b1) begin
                if (first_tick < 0) first_tick = c;
                else second_tick = c;
            end
        end
        check("first_tick_latency", 32'(first_tick), 32'(DROP_PERIOD));
        check("tick_period", 32'(second_tick - first_tick), 32'(DROP_PERIOD));

        // Randomized stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(63) == 0,
                   $urandom_range(7) == 0,
                   $urandom_range(9) == 0,
                   $urandom_range(2) == 0,
                   $urandom_range(3) == 0,
                   ($urandom_range(2) == 0) ? '0 : ROWS'($urandom));
            cycle();
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
